// File: rtl/pattern_mem_pkg.sv
// Shared types and constants for the pattern memory AXI4-Lite front-end.
package pattern_mem_pkg;

  localparam int PATTERN_BITS = 30;
  localparam int MEM_ENTRIES  = 2048;

  typedef enum logic [3:0] {
    IDLE, RD_ADDR, RD_DATA, RD_RESP, WR_RD, WR_MERGE, WR_COMMIT, WR_RESP, CLEAR
  } ctrl_state_t;

  typedef enum logic {RR_READ = 1'b0, RR_WRITE = 1'b1} rr_t;

  function automatic int lanes(input int axi_width);
    return axi_width / 32;
  endfunction

endpackage

// File: rtl/pattern_lane_merge.sv
// Combinational byte merge of packed write data into a stored pattern word.
// Byte 3 of each lane only carries entry bits 29:24; bits 31:30 never reach memory.
module pattern_lane_merge
  import pattern_mem_pkg::*;
#(
  parameter int axi_width = 32
) (
  input  logic [PATTERN_BITS*(axi_width/32)-1:0] old_word,
  input  logic [PATTERN_BITS*(axi_width/32)-1:0] wdata,
  input  logic [axi_width/8-1:0]                 wstrb,
  output logic [PATTERN_BITS*(axi_width/32)-1:0] merged
);

  localparam int LANES = lanes(axi_width);

  function automatic logic [PATTERN_BITS-1:0] merge_lane(
    input logic [PATTERN_BITS-1:0] old_lane,
    input logic [PATTERN_BITS-1:0] new_lane,
    input logic [3:0]              strb
  );
    logic [PATTERN_BITS-1:0] r;
    r = old_lane;
    for (int b = 0; b < 3; b++) begin
      if (strb[b]) r[8*b +: 8] = new_lane[8*b +: 8];
    end
    if (strb[3]) r[29:24] = new_lane[29:24];
    return r;
  endfunction

  always_comb begin
    merged = old_word;
    for (int k = 0; k < LANES; k++) begin
      merged[PATTERN_BITS*k +: PATTERN_BITS] =
        merge_lane(old_word[PATTERN_BITS*k +: PATTERN_BITS],
                   wdata[PATTERN_BITS*k +: PATTERN_BITS],
                   wstrb[4*k +: 4]);
    end
  end

endmodule

// File: rtl/pattern_mem_ctrl.sv
// AXI4-Lite slave owning port A of the pattern memory; serialises reads, full and RMW writes.
// Optional zero-fill on clear_req when PATTERN_MEM_CTRL_CLEAR_EN is defined.
module pattern_mem_ctrl
  import pattern_mem_pkg::*;
#(
  parameter int axi_width  = 32,
  parameter int addr_width = 13
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [addr_width-1:0]                  s_axi_awaddr,
  input  logic                                   s_axi_awvalid,
  output logic                                   s_axi_awready,
  input  logic [axi_width-1:0]                   s_axi_wdata,
  input  logic [axi_width/8-1:0]                 s_axi_wstrb,
  input  logic                                   s_axi_wvalid,
  output logic                                   s_axi_wready,
  output logic [1:0]                             s_axi_bresp,
  output logic                                   s_axi_bvalid,
  input  logic                                   s_axi_bready,
  input  logic [addr_width-1:0]                  s_axi_araddr,
  input  logic                                   s_axi_arvalid,
  output logic                                   s_axi_arready,
  output logic [axi_width-1:0]                   s_axi_rdata,
  output logic [1:0]                             s_axi_rresp,
  output logic                                   s_axi_rvalid,
  input  logic                                   s_axi_rready,
  output logic [10:0]                            mem_a,
  output logic [PATTERN_BITS*(axi_width/32)-1:0] mem_d,
  output logic                                   mem_we,
  input  logic [PATTERN_BITS*(axi_width/32)-1:0] mem_qspo,
  input  logic                                   clear_req,
  output logic                                   busy
);

  localparam int LANES = lanes(axi_width);
  localparam int MW    = PATTERN_BITS * LANES;
  localparam int AW    = 11;
`ifdef PATTERN_MEM_CTRL_CLEAR_EN
  localparam logic [AW-1:0] LAST_WORD = AW'(MEM_ENTRIES - LANES);
  localparam logic [AW-1:0] WORD_STEP = AW'(LANES);
  logic clr_pend;
`endif

  ctrl_state_t            state;
  rr_t                    rr_last;
  logic [MW-1:0]          wdata_q;
  logic [axi_width/8-1:0] wstrb_q;
  logic [MW-1:0]          packed_w;
  logic [MW-1:0]          merged;
  logic [axi_width-1:0]   rd_word;
  logic                   wr_pend;
  logic                   take_wr;
  logic                   unused_ok;

  assign s_axi_bresp = 2'b00;
  assign s_axi_rresp = 2'b00;
  assign wr_pend     = s_axi_awvalid && s_axi_wvalid;
  assign take_wr     = wr_pend && (!s_axi_arvalid || rr_last == RR_READ);

`ifdef PATTERN_MEM_CTRL_CLEAR_EN
  assign unused_ok = ^{s_axi_wdata, s_axi_awaddr[1:0], s_axi_araddr[1:0]};
`else
  assign unused_ok = ^{s_axi_wdata, s_axi_awaddr[1:0], s_axi_araddr[1:0], clear_req};
`endif

  // Lane packing: 32-bit AXI lanes <-> 30-bit memory entries
  always_comb begin
    packed_w = '0;
    rd_word  = '0;
    for (int k = 0; k < LANES; k++) begin
      packed_w[PATTERN_BITS*k +: PATTERN_BITS] = s_axi_wdata[32*k +: PATTERN_BITS];
      rd_word[32*k +: PATTERN_BITS]            = mem_qspo[PATTERN_BITS*k +: PATTERN_BITS];
    end
  end

  pattern_lane_merge #(.axi_width(axi_width)) u_merge (
    .old_word (mem_qspo),
    .wdata    (wdata_q),
    .wstrb    (wstrb_q),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      rr_last       <= RR_READ;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      mem_a         <= '0;
      mem_d         <= '0;
      mem_we        <= 1'b0;
      busy          <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
`ifdef PATTERN_MEM_CTRL_CLEAR_EN
      clr_pend      <= 1'b0;
`endif
    end else begin
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
`ifdef PATTERN_MEM_CTRL_CLEAR_EN
      if (clear_req && state != IDLE && state != CLEAR) clr_pend <= 1'b1;
`endif
      case (state)
        IDLE: begin
`ifdef PATTERN_MEM_CTRL_CLEAR_EN
          if (clr_pend || clear_req) begin
            clr_pend <= 1'b0;
            mem_a    <= '0;
            mem_d    <= '0;
            mem_we   <= 1'b1;
            busy     <= 1'b1;
            state    <= CLEAR;
          end else
`endif
          if (take_wr) begin
            s_axi_awready <= 1'b1;
            s_axi_wready  <= 1'b1;
            rr_last       <= RR_WRITE;
            mem_a         <= s_axi_awaddr[AW+1:2];
            wdata_q       <= packed_w;
            wstrb_q       <= s_axi_wstrb;
            if (&s_axi_wstrb) begin
              mem_d  <= packed_w;
              mem_we <= 1'b1;
              busy   <= 1'b1;
              state  <= WR_COMMIT;
            end else if (|s_axi_wstrb) begin
              busy  <= 1'b1;
              state <= WR_RD;
            end else begin
              // empty strobe: pass through commit without a write so the response still issues
              state <= WR_COMMIT;
            end
          end else if (s_axi_arvalid) begin
            s_axi_arready <= 1'b1;
            rr_last       <= RR_READ;
            mem_a         <= s_axi_araddr[AW+1:2];
            state         <= RD_ADDR;
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          s_axi_rdata  <= rd_word;
          s_axi_rvalid <= 1'b1;
          state        <= RD_RESP;
        end
        RD_RESP: begin
          if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
            state        <= IDLE;
          end
        end
        WR_RD: state <= WR_MERGE;
        WR_MERGE: begin
          mem_d  <= merged;
          mem_we <= 1'b1;
          state  <= WR_COMMIT;
        end
        WR_COMMIT: begin
          mem_we       <= 1'b0;
          busy         <= 1'b0;
          s_axi_bvalid <= 1'b1;
          state        <= WR_RESP;
        end
        WR_RESP: begin
          if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
            state        <= IDLE;
          end
        end
`ifdef PATTERN_MEM_CTRL_CLEAR_EN
        CLEAR: begin
          if (mem_a == LAST_WORD) begin
            mem_we <= 1'b0;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            mem_a <= mem_a + WORD_STEP;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_mem_ctrl.sv
// Directed bench for pattern_mem_ctrl (axi_width=32) with a behavioural port-A memory.
module tb_pattern_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic [12:0] awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, arready, rvalid, rready;
  logic [10:0] mem_a;
  logic [29:0] mem_d, mem_qspo;
  logic        mem_we, clear_req, busy;

  pattern_mem_ctrl #(.axi_width(32), .addr_width(13)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_qspo(mem_qspo),
    .clear_req(clear_req), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-A memory: synchronous write, registered read data one cycle after address
  logic [29:0] mem [0:2047];
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2048; i++) mem[i] <= '0;
      mem_qspo <= '0;
    end else begin
      if (mem_we) mem[mem_a] <= mem_d;
      mem_qspo <= mem[mem_a];
    end
  end

  int          we_cnt, busy_cnt, we_nobusy;
  logic [10:0] last_we_a;
  logic [29:0] last_we_d;
  always @(posedge clk) begin
    if (!rst_n) begin
      we_cnt <= 0; busy_cnt <= 0; we_nobusy <= 0; last_we_a <= '0; last_we_d <= '0;
    end else begin
      if (mem_we) begin
        we_cnt    <= we_cnt + 1;
        last_we_a <= mem_a;
        last_we_d <= mem_d;
        if (!busy) we_nobusy <= we_nobusy + 1;
      end
      if (busy) busy_cnt <= busy_cnt + 1;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int ord_ctr = 0;
  int w_ord, r_ord;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [12:0] a, input logic [31:0] d, input logic [3:0] s);
    int   cyc;
    bit   hs;
    logic [1:0] br;
    @(posedge clk); #1;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    cyc = 0; hs = 1'b0; br = 2'b11;
    while (!hs && cyc < 50) begin
      @(negedge clk);
      if (awready && wready) hs = 1'b1;
      @(posedge clk); #1; cyc++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("aw_w_handshake", 64'(hs), 64'd1);
    w_ord = ++ord_ctr;
    bready = 1'b1; cyc = 0; hs = 1'b0;
    while (!hs && cyc < 50) begin
      @(negedge clk);
      if (bvalid) begin hs = 1'b1; br = bresp; end
      @(posedge clk); #1; cyc++;
    end
    bready = 1'b0;
    check("bvalid_seen", 64'(hs), 64'd1);
    check("bresp", 64'(br), 64'd0);
  endtask

  task automatic do_read(input logic [12:0] a, output logic [31:0] data, output int lat);
    int   cyc;
    bit   hs, got;
    logic [1:0] rr;
    @(posedge clk); #1;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    cyc = 0; hs = 1'b0; got = 1'b0; data = 32'hDEAD_BEEF; lat = -1; rr = 2'b11;
    while (!got && cyc < 50) begin
      @(negedge clk);
      if (arready && arvalid) begin hs = 1'b1; r_ord = ++ord_ctr; end
      if (rvalid) begin got = 1'b1; data = rdata; rr = rresp; lat = cyc; end
      @(posedge clk); #1; cyc++;
      if (hs) arvalid = 1'b0;
    end
    arvalid = 1'b0; rready = 1'b0;
    check("rvalid_seen", 64'(got), 64'd1);
    check("rresp", 64'(rr), 64'd0);
  endtask

  logic [31:0] rd, rd2;
  int          lat, lat2, we0, busy0, nz, cyc;
  bit          bv_ok, ar_seen, started;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; awaddr = '0; araddr = '0; awvalid = 0; wvalid = 0; wdata = '0; wstrb = '0;
    bready = 0; arvalid = 0; rready = 0; clear_req = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_handshakes", 64'({awready, wready, arready, bvalid, rvalid, mem_we, busy}), 64'd0);
    check("reset_mem_a_d", 64'({mem_a, mem_d}), 64'd0);
    check("reset_rdata", 64'(rdata), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_read(13'h010, rd, lat);
    check("read_zero_data", 64'(rd), 64'd0);
    check("read_latency", 64'(lat), 64'd3);

    we0 = we_cnt; busy0 = busy_cnt;
    do_write(13'h010, 32'hFFFF_FFFF, 4'hF);
    check("full_we_count", 64'(we_cnt - we0), 64'd1);
    check("full_we_addr", 64'(last_we_a), 64'd4);
    check("full_we_data", 64'(last_we_d), 64'h3FFF_FFFF);
    check("full_busy_cycles", 64'(busy_cnt - busy0), 64'd1);
    do_read(13'h010, rd, lat);
    check("full_readback", 64'(rd), 64'h3FFF_FFFF);

    we0 = we_cnt; busy0 = busy_cnt;
    do_write(13'h020, 32'h1234_5678, 4'b0010);
    check("rmw_we_count", 64'(we_cnt - we0), 64'd1);
    check("rmw_we_data", 64'(last_we_d), 64'h0000_5600);
    check("rmw_busy_cycles", 64'(busy_cnt - busy0), 64'd3);
    check("rmw_mem_word", 64'(mem[8]), 64'h0000_5600);
    do_read(13'h020, rd, lat);
    check("rmw_readback", 64'(rd), 64'h0000_5600);

    do_write(13'h020, 32'hFFFF_FFFF, 4'b1000);
    do_read(13'h020, rd, lat);
    check("rmw_top_byte_drops_30_31", 64'(rd), 64'h3F00_5600);

    do_write(13'h010, 32'h0000_0000, 4'b0111);
    do_read(13'h010, rd, lat);
    check("rmw_low3_bytes", 64'(rd), 64'h3F00_0000);

    we0 = we_cnt;
    do_write(13'h010, 32'h1234_5678, 4'b0000);
    check("zero_strb_no_we", 64'(we_cnt - we0), 64'd0);
    do_read(13'h010, rd, lat);
    check("zero_strb_unchanged", 64'(rd), 64'h3F00_0000);

    // rr_last is READ here: write wins the first collision
    we0 = we_cnt;
    fork
      do_write(13'h030, 32'h0000_0ABC, 4'hF);
      do_read(13'h010, rd, lat);
    join
    check("pair1_write_first", 64'(w_ord < r_ord), 64'd1);
    check("pair1_read_data", 64'(rd), 64'h3F00_0000);
    check("pair1_we_count", 64'(we_cnt - we0), 64'd1);

    do_write(13'h034, 32'h0000_0011, 4'hF);
    // rr_last is WRITE here: read wins the second collision
    fork
      do_write(13'h038, 32'h0000_0022, 4'hF);
      do_read(13'h030, rd, lat);
    join
    check("pair2_read_first", 64'(r_ord < w_ord), 64'd1);
    check("pair2_read_data", 64'(rd), 64'h0000_0ABC);
    do_read(13'h038, rd, lat);
    check("pair2_write_landed", 64'(rd), 64'h0000_0022);

    // Response back-pressure with a read waiting
    @(posedge clk); #1;
    awaddr = 13'h040; wdata = 32'h0000_0055; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    cyc = 0; started = 0;
    while (!started && cyc < 50) begin
      @(negedge clk);
      if (awready && wready) started = 1;
      @(posedge clk); #1; cyc++;
    end
    awvalid = 0; wvalid = 0; araddr = 13'h034; arvalid = 1;
    check("bp_handshake", 64'(started), 64'd1);
    cyc = 0;
    while (!bvalid && cyc < 50) begin @(negedge clk); cyc++; end
    we0 = we_cnt; bv_ok = 1; ar_seen = 0;
    repeat (10) begin
      @(negedge clk);
      bv_ok   = bv_ok & bvalid;
      ar_seen = ar_seen | arready;
    end
    check("bp_bvalid_held", 64'(bv_ok), 64'd1);
    check("bp_arready_low", 64'(ar_seen), 64'd0);
    check("bp_no_mem_access", 64'(we_cnt - we0), 64'd0);
    bready = 1; arvalid = 0;
    @(posedge clk); #1 bready = 0;
    do_read(13'h034, rd, lat);
    check("bp_read_after", 64'(rd), 64'h0000_0011);
    check("bp_read_latency", 64'(lat), 64'd3);
    do_read(13'h040, rd2, lat2);
    check("bp_write_landed", 64'(rd2), 64'h0000_0055);

`ifdef PATTERN_MEM_CTRL_CLEAR_EN
    do_write(13'h7FC, 32'h1555_AAAA, 4'hF);
    we0 = we_cnt; busy0 = busy_cnt;
    @(posedge clk); #1 clear_req = 1;
    @(posedge clk); #1 clear_req = 0;
    cyc = 0; started = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      if (busy) started = 1;
      else if (started) break;
      cyc++;
    end
    check("clear_we_count", 64'(we_cnt - we0), 64'd2048);
    check("clear_busy_cycles", 64'(busy_cnt - busy0), 64'd2048);
    nz = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] != 30'd0) nz++;
    check("clear_mem_zero", 64'(nz), 64'd0);
    do_read(13'h7FC, rd, lat);
    check("clear_read_zero", 64'(rd), 64'd0);
`else
    we0 = we_cnt; busy0 = busy_cnt;
    @(posedge clk); #1 clear_req = 1;
    @(posedge clk); #1 clear_req = 0;
    repeat (6) @(posedge clk);
    check("clear_ignored_we", 64'(we_cnt - we0), 64'd0);
    check("clear_ignored_busy", 64'(busy_cnt - busy0), 64'd0);
    do_read(13'h040, rd, lat);
    check("clear_ignored_data", 64'(rd), 64'h0000_0055);
`endif

    check("we_always_busy", 64'(we_nobusy), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
